// File: rtl/rx_to_mem_if.sv
// Loader bus: UART line and load request in, memory write port and status out.
interface rx_to_mem_if;
    logic       rx_data;
    logic       load_en;
    logic       write;
    logic [5:0] write_address;
    logic [7:0] write_value;
    logic       busy;
    logic       done;
    logic       frame_err;

    // The loader drives the memory write port and status flags.
    modport master (
        input  rx_data,
        input  load_en,
        output write,
        output write_address,
        output write_value,
        output busy,
        output done,
        output frame_err
    );

    // The serial source / session controller drives the line and load request.
    modport slave (
        output rx_data,
        output load_en,
        input  write,
        input  write_address,
        input  write_value,
        input  busy,
        input  done,
        input  frame_err
    );
endinterface

// File: rtl/rx_to_mem.sv
// Serial operand loader: 8N1 UART receiver feeding consecutive writes into a
// matrix memory. One session loads ROWS*COLS bytes, row-major from address 0.
module rx_to_mem #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ROWS         = 2,
    parameter int COLS         = 2
) (
    input  logic         clk,
    input  logic         rst,
    rx_to_mem_if.master  bus
);
    localparam int             TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]     LAST_IDX = 7'(ROWS * COLS - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE}          ld_state_t;

    logic            r_sync1, r_sync2;
    rx_state_t       r_rx_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    ld_state_t       r_ld_state;
    logic [6:0]      r_count;
    logic            r_write;
    logic [5:0]      r_addr;
    logic [7:0]      r_value;
    logic            r_busy;
    logic            r_done;
    logic            r_ferr;

    logic            w_rx_s;
    logic            w_stop_sample;
    logic            w_byte_valid;
    logic            w_frame_bad;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx_data;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // UART receiver: find start edge, confirm at mid start bit, then sample
    // each data bit and the stop bit at their centres.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) r_rx_state <= R_START;
                end
                R_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer    <= '0;
                        r_rx_state <= w_rx_s ? R_IDLE : R_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_timer == FULL_M1) begin
                        r_timer   <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_rx_state <= R_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                R_STOP: begin
                    // Re-arm right after the mid-stop sample so a start edge in
                    // the back half of the stop bit is still caught.
                    if (r_timer == FULL_M1) begin
                        r_timer    <= '0;
                        r_rx_state <= R_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    assign w_stop_sample = (r_rx_state == R_STOP) && (r_timer == FULL_M1);
    assign w_byte_valid  = w_stop_sample &&  w_rx_s;
    assign w_frame_bad   = w_stop_sample && !w_rx_s;

    // Loader session FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_state <= L_IDLE;
            r_count    <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_value    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            if (w_frame_bad && r_busy) r_ferr <= 1'b1;
            case (r_ld_state)
                L_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.load_en) begin
                        r_ld_state <= L_LOAD;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_ferr     <= 1'b0;   // new session: clearing beats any set
                    end
                end
                L_LOAD: begin
                    if (w_byte_valid) begin
                        r_write <= 1'b1;
                        r_addr  <= r_count[5:0];
                        r_value <= r_shift;
                        r_count <= r_count + 7'd1;
                        if (r_count == LAST_IDX) r_ld_state <= L_DONE;
                    end
                end
                L_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_ld_state <= L_IDLE;
                end
                default: r_ld_state <= L_IDLE;
            endcase
        end
    end

    assign bus.write         = r_write;
    assign bus.write_address = r_addr;
    assign bus.write_value   = r_value;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.frame_err     = r_ferr;

endmodule
